// File: rtl/rx_fsrc_remove_holes.sv
// rx_fsrc_remove_holes
// Drops hole words from each input beat and packs the survivors, order
// preserved, into dense NUM_WORDS-word output beats.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   in_data       NUM_DATA lanes of NUM_WORDS words, word k at [k*WORD_LENGTH +: WORD_LENGTH]
//   in_holes      bit k set: word k of every lane is discarded
//   in_valid      input beat valid
//   in_ready      input beat accepted when in_valid && in_ready
//   out_data      dense output beat, same lane/word layout as in_data
//   out_valid     output beat valid
//   out_ready     output beat accepted when out_valid && out_ready
//   fill_level    words currently held in the pack buffer
module rx_fsrc_remove_holes #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned NUM_WORDS   = 8,
  parameter int unsigned NUM_DATA    = 8
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic [NUM_DATA-1:0][WORD_LENGTH*NUM_WORDS-1:0]  in_data,
  input  logic [NUM_WORDS-1:0]                            in_holes,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  output logic [NUM_DATA-1:0][WORD_LENGTH*NUM_WORDS-1:0]  out_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [$clog2(2*NUM_WORDS+1)-1:0]                fill_level
);

  localparam int unsigned LANE_W    = WORD_LENGTH * NUM_WORDS;
  localparam int unsigned BUF_WORDS = 2 * NUM_WORDS;
  localparam int unsigned FILL_W    = $clog2(BUF_WORDS + 1);
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
  localparam int unsigned BUF_IDX_W = $clog2(BUF_WORDS);

  // Stage 1 state: compacted beat waiting to be appended
  logic                                               stage_valid_q, stage_valid_d;
  logic [CNT_W-1:0]                                   stage_cnt_q, stage_cnt_d;
  logic [NUM_DATA-1:0][NUM_WORDS-1:0][WORD_LENGTH-1:0] stage_q, comp_d;

  // Stage 2 state: pack buffer (word 0 oldest) and output register
  logic [FILL_W-1:0]                                  fill_q, fill_d, fill_post;
  logic [NUM_DATA-1:0][BUF_WORDS-1:0][WORD_LENGTH-1:0] buf_q, buf_d;
  logic                                               out_valid_q, out_valid_d;
  logic [NUM_DATA-1:0][LANE_W-1:0]                    out_data_q;

  logic in_xfer;
  logic out_load;
  logic stage_append;

  // Handshake and buffer occupancy bookkeeping
  always_comb begin
    out_load     = (fill_q >= FILL_W'(NUM_WORDS)) && (!out_valid_q || out_ready);
    fill_post    = out_load ? (fill_q - FILL_W'(NUM_WORDS)) : fill_q;
    // Appending only when at most NUM_WORDS words remain keeps the buffer from overflowing
    stage_append = stage_valid_q && (fill_post <= FILL_W'(NUM_WORDS));
    in_ready     = reset_n && (!stage_valid_q || stage_append);
    in_xfer      = in_valid && in_ready;
  end

  // Compaction: running count of non-holes gives each survivor its packed slot
  always_comb begin
    logic [CNT_W-1:0] pos;
    comp_d = '0;
    pos    = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (!in_holes[k]) begin
        for (int unsigned l = 0; l < NUM_DATA; l++) begin
          comp_d[l][IDX_W'(pos)] = in_data[l][k*WORD_LENGTH +: WORD_LENGTH];
        end
        pos = pos + CNT_W'(1);
      end
    end
    stage_cnt_d = pos;
  end

  // Stage valid tracks accepted beats until they are appended
  always_comb begin
    stage_valid_d = stage_valid_q;
    if (in_xfer) begin
      stage_valid_d = 1'b1;
    end else if (stage_append) begin
      stage_valid_d = 1'b0;
    end
  end

  // Pack buffer next state: shift out the oldest group, then append the staged words
  always_comb begin
    logic [FILL_W-1:0] idx;
    buf_d = buf_q;
    idx   = '0;
    if (out_load) begin
      for (int unsigned l = 0; l < NUM_DATA; l++) begin
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
          buf_d[l][i] = buf_q[l][i + NUM_WORDS];
        end
      end
    end
    if (stage_append) begin
      for (int unsigned j = 0; j < NUM_WORDS; j++) begin
        idx = fill_post + FILL_W'(j);
        if (CNT_W'(j) < stage_cnt_q) begin
          for (int unsigned l = 0; l < NUM_DATA; l++) begin
            buf_d[l][BUF_IDX_W'(idx)] = stage_q[l][j];
          end
        end
      end
    end
    fill_d = fill_post + (stage_append ? FILL_W'(stage_cnt_q) : FILL_W'(0));
  end

  // Output valid: set on load, cleared once the held beat is taken
  always_comb begin
    out_valid_d = out_valid_q;
    if (out_load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid_q <= 1'b0;
      stage_cnt_q   <= '0;
      fill_q        <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      if (in_xfer) begin
        stage_cnt_q <= stage_cnt_d;
      end
      fill_q        <= fill_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // Data registers carry no reset; their contents are qualified by the control state
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      stage_q <= comp_d;
    end
    buf_q <= buf_d;
    if (out_load) begin
      for (int unsigned l = 0; l < NUM_DATA; l++) begin
        out_data_q[l] <= buf_q[l][NUM_WORDS-1:0];
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign fill_level = fill_q;

endmodule

// File: tb/tb_rx_fsrc_remove_holes.sv
// Bench for rx_fsrc_remove_holes: cycle table for full and alternating-hole
// beats, then directed sequences for all-hole, split, backpressure and reset.
module tb_rx_fsrc_remove_holes;

  localparam int unsigned WL = 8;
  localparam int unsigned NW = 8;
  localparam int unsigned ND = 2;
  localparam int unsigned BW = WL * NW;
  localparam int unsigned FW = $clog2(2 * NW + 1);

  logic                   clk;
  logic                   reset_n;
  logic [ND-1:0][BW-1:0]  in_data;
  logic [NW-1:0]          in_holes;
  logic                   in_valid;
  logic                   in_ready;
  logic [ND-1:0][BW-1:0]  out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [FW-1:0]          fill_level;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  rx_fsrc_remove_holes #(
    .WORD_LENGTH (WL),
    .NUM_WORDS   (NW),
    .NUM_DATA    (ND)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_holes   (in_holes),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  holes;
    logic [7:0]  base;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [4:0]  exp_fill;
    logic [63:0] exp_out;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lane word k = (base + k) ^ x
  function automatic logic [BW-1:0] beat(input logic [7:0] base, input logic [7:0] x);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < NW; k++) begin
      r[k*WL +: WL] = (base + 8'(k)) ^ x;
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [7:0] holes, input logic [7:0] base);
    in_valid = v;
    in_holes = holes;
    in_data[0] = beat(base, 8'h00);
    in_data[1] = beat(base, 8'h80);
  endtask

  // Scoreboard: every surviving input word must come out once, in order
  always @(negedge clk) begin
    if (!reset_n) begin
      sb0.delete();
      sb1.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb0.size() < NW) begin
          chk("sb_underflow", 64'(sb0.size()), 64'(NW));
        end else begin
          logic [BW-1:0] e0, e1;
          for (int k = 0; k < NW; k++) begin
            e0[k*WL +: WL] = sb0.pop_front();
            e1[k*WL +: WL] = sb1.pop_front();
          end
          chk("sb_lane0", 64'(out_data[0]), 64'(e0));
          chk("sb_lane1", 64'(out_data[1]), 64'(e1));
        end
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < NW; k++) begin
          if (!in_holes[k]) begin
            sb0.push_back(in_data[0][k*WL +: WL]);
            sb1.push_back(in_data[1][k*WL +: WL]);
          end
        end
      end
    end
  end

  // Run until the output side is idle with exp_fill words held, then check
  task automatic drain(input string name, input int unsigned exp_fill);
    int stable;
    stable = 0;
    for (int c = 0; c < 100 && stable < 3; c++) begin
      @(negedge clk);
      if (!out_valid && fill_level == FW'(exp_fill)) stable++;
      else stable = 0;
      @(posedge clk); #1;
    end
    chk({name, "_fill"}, 64'(fill_level), 64'(exp_fill));
    chk({name, "_ov"}, 64'(out_valid), 64'(0));
    chk({name, "_sb"}, 64'(sb0.size()), 64'(exp_fill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned bi;
    logic acc;

    reset_n   = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    #2;
    chk("rst_ov", 64'(out_valid), 64'(0));
    chk("rst_fill", 64'(fill_level), 64'(0));
    chk("rst_ir", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Per-cycle table: full beats back to back, then two 0xAA beats
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0};
    vecs[1]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0};
    vecs[2]  = '{1'b1, 8'h00, 8'h08, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0};
    vecs[3]  = '{1'b1, 8'h00, 8'h10, 1'b1, 1'b1, 1'b0, 5'd8, 64'h0};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 5'd8, 64'(beat(8'h00, 8'h00))};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 5'd8, 64'(beat(8'h08, 8'h00))};
    vecs[6]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 5'd0, 64'(beat(8'h10, 8'h00))};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0};
    vecs[8]  = '{1'b1, 8'hAA, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0};
    vecs[9]  = '{1'b1, 8'hAA, 8'h10, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 5'd4, 64'h0};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 5'd8, 64'h0};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 5'd0, 64'h16141210_06040200};
    vecs[13] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].vld, vecs[i].holes, vecs[i].base);
      out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("row%0d_ir", i), 64'(in_ready), 64'(vecs[i].exp_ir));
      chk($sformatf("row%0d_ov", i), 64'(out_valid), 64'(vecs[i].exp_ov));
      chk($sformatf("row%0d_fill", i), 64'(fill_level), 64'(vecs[i].exp_fill));
      if (vecs[i].exp_ov) begin
        chk($sformatf("row%0d_out", i), 64'(out_data[0]), vecs[i].exp_out);
      end
      @(posedge clk); #1;
    end

    // All-hole beats are swallowed without producing output
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'hFF, 8'(i * 8));
      @(negedge clk);
      chk($sformatf("holes%0d_ir", i), 64'(in_ready), 64'(1));
      chk($sformatf("holes%0d_ov", i), 64'(out_valid), 64'(0));
      chk($sformatf("holes%0d_fill", i), 64'(fill_level), 64'(0));
      @(posedge clk); #1;
    end
    drive(1'b0, 8'h00, 8'h00);
    drain("holes", 0);

    // Half beats with early backpressure: buffer reaches 12, then shift-out and append overlap
    bi = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 60 && bi < 8; cyc++) begin
      out_ready = (cyc >= 6);
      drive(1'b1, bi[0] ? 8'h0F : 8'hF0, 8'(bi * 8));
      @(negedge clk);
      if (cyc == 6) chk("split_fill12", 64'(fill_level), 64'(12));
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) bi++;
    end
    chk("split_sent", 64'(bi), 64'(8));
    drive(1'b0, 8'h00, 8'h00);
    out_ready = 1'b1;
    drain("split", 0);

    // Backpressure: one beat held, buffer full, input stalls; then release
    bi = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(1'b1, 8'h00, 8'(8'h80 + bi * 8));
      @(negedge clk);
      if (cyc == 6) begin
        chk("bp_ir", 64'(in_ready), 64'(0));
        chk("bp_ov", 64'(out_valid), 64'(1));
        chk("bp_fill", 64'(fill_level), 64'(16));
        chk("bp_word", 64'(out_data[0]), 64'(beat(8'h80, 8'h00)));
      end
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) bi++;
    end
    chk("bp_accepted", 64'(bi), 64'(4));
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && bi < 8; cyc++) begin
      drive(1'b1, 8'h00, 8'(8'h80 + bi * 8));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) bi++;
    end
    chk("bp_sent", 64'(bi), 64'(8));
    drive(1'b0, 8'h00, 8'h00);
    drain("bp", 0);

    // Reset mid-operation with a held output beat and 5 buffered words
    out_ready = 1'b0;
    drive(1'b1, 8'h00, 8'h20);
    @(posedge clk); #1;
    drive(1'b1, 8'hE0, 8'h30);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_ov", 64'(out_valid), 64'(1));
    chk("pre_rst_fill", 64'(fill_level), 64'(5));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ov", 64'(out_valid), 64'(0));
    chk("mid_rst_fill", 64'(fill_level), 64'(0));
    chk("mid_rst_ir", 64'(in_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ir2", 64'(in_ready), 64'(0));
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 8'h0F, 8'h40);
    @(posedge clk); #1;
    drive(1'b1, 8'hF0, 8'h50);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 8'h00);
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge clk);
      if (out_valid) begin
        acc = 1'b1;
        chk("post_rst_lane0", 64'(out_data[0]), 64'h53525150_47464544);
        chk("post_rst_lane1", 64'(out_data[1]), 64'hD3D2D1D0_C7C6C5C4);
      end
      @(posedge clk); #1;
    end
    chk("post_rst_seen", 64'(acc), 64'(1));
    drain("post_rst", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
